// File: rtl/cve2_trace_pkg.sv
// cve2_trace_pkg: record layout, header bit positions and header packing for the RVFI trace packer.
package cve2_trace_pkg;
   localparam int TraceWords = 4;
   localparam int HdrOvf     = 31;
   localparam int HdrTrap    = 30;
   localparam int HdrIntr    = 29;
   localparam int HdrModeLo  = 27;
   localparam int HdrRdLo    = 22;
   localparam int HdrRdWe    = 21;
   localparam int HdrOrderLo = 0;
   typedef struct packed {
      logic [15:0] order_lo;
      logic        trap;
      logic        intr;
      logic [1:0]  mode;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc;
      logic [31:0] insn;
   } trace_rec_t;
   function automatic logic [31:0] pack_hdr(logic ovf, trace_rec_t r);
      logic [31:0] h;
      h = '0;
      h[HdrOvf] = ovf;
      h[HdrTrap] = r.trap;
      h[HdrIntr] = r.intr;
      h[HdrModeLo +: 2] = r.mode;
      h[HdrRdLo +: 5] = r.rd_addr;
      h[HdrRdWe] = |r.rd_addr;
      h[HdrOrderLo +: 16] = r.order_lo;
      return h;
   endfunction
endpackage

// File: rtl/cve2_trace_packer_if.sv
// cve2_trace_packer_if: RVFI retirement inputs plus the outgoing valid/ready trace word stream.
interface cve2_trace_packer_if;
   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_intr;
   logic [1:0]  rvfi_mode;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic [31:0] rvfi_pc_rdata;
   logic        trace_valid_o;
   logic        trace_ready_i;
   logic [31:0] trace_data_o;
   logic        trace_last_o;
   modport master (
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_mode,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, trace_ready_i,
      output trace_valid_o, trace_data_o, trace_last_o
   );
   modport slave (
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_mode,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, trace_ready_i,
      input  trace_valid_o, trace_data_o, trace_last_o
   );
endinterface

// File: rtl/cve2_trace_fifo.sv
// cve2_trace_fifo: synchronous record FIFO; extra pointer bit distinguishes full from empty.
module cve2_trace_fifo
   import cve2_trace_pkg::*;
#(
   parameter int Depth = 8,
   localparam int AW = $clog2(Depth)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  trace_rec_t wdata,
   output trace_rec_t rdata,
   output logic       full,
   output logic       empty,
   output logic [AW:0] level
);
   trace_rec_t mem [Depth];
   logic [AW:0] wptr, rptr;
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end
   end
   assign level = wptr - rptr;
   assign full  = level == (AW+1)'(Depth);
   assign empty = level == '0;
   assign rdata = mem[rptr[AW-1:0]];
endmodule

// File: rtl/cve2_trace_packer.sv
// cve2_trace_packer: captures RVFI retirements into a FIFO and streams each as four 32-bit words;
// records that find the FIFO full are dropped and counted so the core is never stalled.
module cve2_trace_packer
   import cve2_trace_pkg::*;
#(
   parameter int Depth  = 8,
   parameter int LevelW = $clog2(Depth+1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              trace_en_i,
   cve2_trace_packer_if.master bus,
   output logic [15:0]       drop_cnt_o,
   output logic [LevelW-1:0] fifo_level_o
);
   trace_rec_t rec, head;
   logic [1:0] wcnt;
   logic ovf, full, empty, push_req, push, pop, hs, drop;
   logic unused_order;
   assign unused_order = ^bus.rvfi_order[63:16];
   assign rec = '{order_lo: bus.rvfi_order[15:0], trap: bus.rvfi_trap, intr: bus.rvfi_intr,
                  mode: bus.rvfi_mode, rd_addr: bus.rvfi_rd_addr, rd_wdata: bus.rvfi_rd_wdata,
                  pc: bus.rvfi_pc_rdata, insn: bus.rvfi_insn};
   assign hs       = !empty && bus.trace_ready_i;
   assign pop      = hs && wcnt == 2'(TraceWords-1);
   assign push_req = bus.rvfi_valid && trace_en_i;
   // A W3 pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && !push;
   cve2_trace_fifo #(.Depth(Depth)) u_fifo (
      .clk(clk_i), .rst(rst_i), .push(push), .pop(pop), .wdata(rec),
      .rdata(head), .full(full), .empty(empty), .level(fifo_level_o)
   );
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wcnt       <= '0;
         ovf        <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         if (hs) wcnt <= wcnt + 1'b1;
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
         end else if (hs && wcnt == 2'd0) begin
            ovf <= 1'b0;
         end
      end
   end
   always_comb begin
      bus.trace_valid_o = !empty;
      bus.trace_last_o  = !empty && wcnt == 2'(TraceWords-1);
      bus.trace_data_o  = empty      ? '0 :
                          wcnt == 0  ? pack_hdr(ovf, head) :
                          wcnt == 1  ? head.pc :
                          wcnt == 2  ? head.insn :
                          (head.rd_addr == '0 ? '0 : head.rd_wdata);
   end
endmodule

// File: tb/tb_cve2_trace_packer.sv
// tb_cve2_trace_packer: directed bench; expected words queued at retirement, checked at each handshake.
module tb_cve2_trace_packer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic [15:0] drop;
   logic [3:0] level;
   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;
   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   int hs_cnt = 0;

   cve2_trace_packer_if bus();
   cve2_trace_packer #(.Depth(8)) dut (
      .clk_i(clk), .rst_i(rst), .trace_en_i(en), .bus(bus),
      .drop_cnt_o(drop), .fifo_level_o(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (bus.trace_valid_o && bus.trace_ready_i) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", bus.trace_data_o, e.d);
            chk("word_last", 32'(bus.trace_last_o), 32'(e.l));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_rec(input logic ovf, input logic [15:0] ord, input logic trap, input logic intr,
                           input logic [1:0] mode, input logic [4:0] rd, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [31:0] insn);
      exp_q.push_back('{{ovf, trap, intr, mode, rd, rd != 5'd0, 5'd0, ord}, 1'b0});
      exp_q.push_back('{pc, 1'b0});
      exp_q.push_back('{insn, 1'b0});
      exp_q.push_back('{(rd == 5'd0) ? 32'd0 : wd, 1'b1});
   endtask

   task automatic retire(input logic [15:0] ord, input logic trap, input logic intr,
                         input logic [1:0] mode, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [31:0] insn);
      bus.rvfi_order    = {32'($urandom), 16'hABCD, ord};
      bus.rvfi_trap     = trap;
      bus.rvfi_intr     = intr;
      bus.rvfi_mode     = mode;
      bus.rvfi_rd_addr  = rd;
      bus.rvfi_rd_wdata = wd;
      bus.rvfi_pc_rdata = pc;
      bus.rvfi_insn     = insn;
      bus.rvfi_valid    = 1'b1;
      tick();
      bus.rvfi_valid    = 1'b0;
   endtask

   task automatic drain();
      bus.trace_ready_i = 1'b1;
      for (int i = 0; i < 200 && bus.trace_valid_o; i++) tick();
      chk("drain_done", 32'(bus.trace_valid_o), 32'd0);
   endtask

   initial begin
      bus.rvfi_valid = 1'b0;
      bus.rvfi_order = '0;
      bus.rvfi_insn = '0;
      bus.rvfi_trap = 1'b0;
      bus.rvfi_intr = 1'b0;
      bus.rvfi_mode = '0;
      bus.rvfi_rd_addr = '0;
      bus.rvfi_rd_wdata = '0;
      bus.rvfi_pc_rdata = '0;
      bus.trace_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.trace_valid_o), 32'd0);
      chk("rst_data", bus.trace_data_o, 32'd0);
      chk("rst_last", 32'(bus.trace_last_o), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      rst = 1'b0;

      bus.trace_ready_i = 1'b1;
      exp_q.push_back('{32'h0060_0005, 1'b0});
      exp_q.push_back('{32'h0000_0180, 1'b0});
      exp_q.push_back('{32'h0010_0093, 1'b0});
      exp_q.push_back('{32'h0000_0001, 1'b1});
      retire(16'd5, 1'b0, 1'b0, 2'd0, 5'd1, 32'd1, 32'h0000_0180, 32'h0010_0093);
      chk("latency_valid", 32'(bus.trace_valid_o), 32'd1);
      drain();

      push_rec(1'b0, 16'd6, 1'b1, 1'b0, 2'b11, 5'd10, 32'hCAFE_0001, 32'h0000_0200, 32'h00A0_0513);
      retire(16'd6, 1'b1, 1'b0, 2'b11, 5'd10, 32'hCAFE_0001, 32'h0000_0200, 32'h00A0_0513);
      tick();
      bus.trace_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(bus.trace_valid_o), 32'd1);
         chk("bp_data", bus.trace_data_o, 32'h0000_0200);
         chk("bp_last", 32'(bus.trace_last_o), 32'd0);
         tick();
      end
      drain();

      bus.trace_ready_i = 1'b0;
      push_rec(1'b0, 16'd7, 1'b0, 1'b1, 2'b01, 5'd0, 32'h0000_0055, 32'h0000_0300, 32'h0000_0013);
      retire(16'd7, 1'b0, 1'b1, 2'b01, 5'd0, 32'h0000_0055, 32'h0000_0300, 32'h0000_0013);
      push_rec(1'b0, 16'd8, 1'b0, 1'b0, 2'b11, 5'd3, 32'h1234_5678, 32'h0000_0304, 32'h0030_0193);
      retire(16'd8, 1'b0, 1'b0, 2'b11, 5'd3, 32'h1234_5678, 32'h0000_0304, 32'h0030_0193);
      en = 1'b0;
      for (int i = 0; i < 3; i++)
         retire(16'(100 + i), 1'b0, 1'b0, 2'b11, 5'd4, 32'hBAD0_0000, 32'h0000_0900, 32'h0000_0013);
      chk("dis_level", 32'(level), 32'd2);
      chk("dis_drop", 32'(drop), 32'd0);
      en = 1'b1;
      hs_cnt = 0;
      drain();
      chk("dis_words", 32'(hs_cnt), 32'd8);
      chk("dis_drop_after", 32'(drop), 32'd0);

      bus.trace_ready_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i < 8)
            push_rec(i == 0, 16'(16 + i), 1'b0, 1'b0, 2'b11, 5'(i + 1), 32'h1000 + 32'(i),
                     32'h400 + 32'(4 * i), 32'h13 + 32'(i << 7));
         retire(16'(16 + i), 1'b0, 1'b0, 2'b11, 5'(i + 1), 32'h1000 + 32'(i),
                32'h400 + 32'(4 * i), 32'h13 + 32'(i << 7));
      end
      chk("ovf_level", 32'(level), 32'd8);
      chk("ovf_drop", 32'(drop), 32'd4);
      drain();
      chk("ovf_drop_after", 32'(drop), 32'd4);

      bus.trace_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_rec(1'b0, 16'(32 + i), 1'b0, 1'b0, 2'b00, 5'd7, 32'h2000 + 32'(i), 32'h800 + 32'(4 * i), 32'h0000_0073);
         retire(16'(32 + i), 1'b0, 1'b0, 2'b00, 5'd7, 32'h2000 + 32'(i), 32'h800 + 32'(4 * i), 32'h0000_0073);
      end
      chk("full_level", 32'(level), 32'd8);
      bus.trace_ready_i = 1'b1;
      repeat (3) tick();
      chk("full_w3_last", 32'(bus.trace_last_o), 32'd1);
      push_rec(1'b0, 16'd40, 1'b0, 1'b0, 2'b01, 5'd9, 32'h3333_0000, 32'h0000_0A00, 32'h0000_0033);
      retire(16'd40, 1'b0, 1'b0, 2'b01, 5'd9, 32'h3333_0000, 32'h0000_0A00, 32'h0000_0033);
      chk("full_drop", 32'(drop), 32'd4);
      chk("full_level_same", 32'(level), 32'd8);
      drain();

      push_rec(1'b0, 16'd50, 1'b0, 1'b0, 2'b11, 5'd2, 32'h4444_0000, 32'h0000_0B00, 32'h0000_0113);
      retire(16'd50, 1'b0, 1'b0, 2'b11, 5'd2, 32'h4444_0000, 32'h0000_0B00, 32'h0000_0113);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.trace_valid_o), 32'd0);
      chk("mid_rst_data", bus.trace_data_o, 32'd0);
      chk("mid_rst_last", 32'(bus.trace_last_o), 32'd0);
      chk("mid_rst_drop", 32'(drop), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      push_rec(1'b0, 16'd51, 1'b0, 1'b0, 2'b11, 5'd6, 32'h5555_0000, 32'h0000_0C00, 32'h0000_0213);
      retire(16'd51, 1'b0, 1'b0, 2'b11, 5'd6, 32'h5555_0000, 32'h0000_0C00, 32'h0000_0213);
      chk("post_rst_w0", bus.trace_data_o, {1'b0, 1'b0, 1'b0, 2'b11, 5'd6, 1'b1, 5'd0, 16'd51});
      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
